// File: rtl/digital_sensor_pkg.sv
// Shared definitions for the sensor command link: frame geometry and the
// response framer's FSM state encodings.
package digital_sensor_pkg;

  localparam int BYTE_W         = 8;
  localparam int FRAME_LEN_BASE = 2;
  localparam int FRAME_LEN_CSUM = 3;

  // Framer FSM encodings, kept as plain constants for legacy tooling
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

endpackage

// File: rtl/framer_timer.sv
// Loadable up-counter with a terminal-count flag. The framer reuses one
// instance for both the inter-byte gap and the per-byte timeout.
module framer_timer #(
  parameter int WIDTH = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] terminal_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Load takes priority over counting so a new interval always starts clean
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == terminal_i);

endmodule

// File: rtl/response_framer.sv
// Transmit-side response framer: packs code/value (and optional checksum)
// and hands bytes one at a time to UART_TX via has_data/transmission_done.
// Optional feature macro: RESPONSE_FRAMER_CHECKSUM_EN adds a third byte,
// code ^ value, to every frame.
module response_framer
  import digital_sensor_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              request_valid,
  output logic              request_ready,
  input  logic [BYTE_W-1:0] response_code,
  input  logic [BYTE_W-1:0] response_value,
  output logic              has_data,
  output logic [BYTE_W-1:0] data_to_send,
  input  logic              transmission_done,
  output logic              frame_done,
  output logic              timeout_error,
  output logic [BYTE_W-1:0] frame_count
);

`ifdef RESPONSE_FRAMER_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1);
  localparam logic [TIMER_W-1:0] GAP_TERM     = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_TERM = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        index_q, index_d;
  logic [BYTE_W-1:0] code_q, code_d;
  logic [BYTE_W-1:0] value_q, value_d;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif
  logic              has_data_q, has_data_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              frame_done_q, frame_done_d;
  logic              timeout_q, timeout_d;
  logic [BYTE_W-1:0] count_q, count_d;

  logic               timer_load, timer_en, timer_tc;
  logic [TIMER_W-1:0] timer_term;
  logic [BYTE_W-1:0]  byte_sel;

  // The gap and the timeout share one counter; only the terminal differs
  assign timer_term = (state_q == ST_GAP) ? GAP_TERM : TIMEOUT_TERM;

  framer_timer #(.WIDTH(TIMER_W)) u_timer (
    .clock        (clock),
    .reset        (reset),
    .load_i       (timer_load),
    .load_value_i ('0),
    .enable_i     (timer_en),
    .terminal_i   (timer_term),
    .tc_o         (timer_tc)
  );

  // Pick the latched frame byte addressed by the current index
  always_comb begin
    byte_sel = '0;
    case (index_q)
      2'd0:    byte_sel = code_q;
      2'd1:    byte_sel = value_q;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
      2'd2:    byte_sel = csum_q;
`endif
      default: byte_sel = '0;
    endcase
  end

  // FSM next-state and datapath: the timer restarts on entry to SEND so it
  // covers the strobe plus the wait, and restarts again on entry to GAP
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    code_d       = code_q;
    value_d      = value_q;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    has_data_d   = 1'b0;
    data_d       = data_q;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;
    count_d      = count_q;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (request_valid) begin
          code_d     = response_code;
          value_d    = response_value;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
          csum_d     = response_code ^ response_value;
`endif
          index_d    = 2'd0;
          has_data_d = 1'b1;
          data_d     = response_code;
          timer_load = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        timer_en = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (transmission_done) begin
          if (index_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            count_d      = count_q + 8'd1;
            state_d      = ST_IDLE;
          end else begin
            index_d    = index_q + 2'd1;
            timer_load = 1'b1;
            state_d    = ST_GAP;
          end
        end else if (timer_tc) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        if (timer_tc) begin
          has_data_d = 1'b1;
          data_d     = byte_sel;
          timer_load = 1'b1;
          state_d    = ST_SEND;
        end else begin
          timer_en = 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      index_q      <= 2'd0;
      code_q       <= '0;
      value_q      <= '0;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
      csum_q       <= '0;
`endif
      has_data_q   <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      code_q       <= code_d;
      value_q      <= value_d;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      has_data_q   <= has_data_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end

  assign request_ready = (state_q == ST_IDLE);
  assign has_data      = has_data_q;
  assign data_to_send  = data_q;
  assign frame_done    = frame_done_q;
  assign timeout_error = timeout_q;
  assign frame_count   = count_q;

endmodule

// File: tb/tb_response_framer.sv
// Directed bench for response_framer; plays the UART_TX side by returning
// a transmission_done pulse a fixed number of clocks after each has_data.
module tb_response_framer;

  localparam int GAP = 2;
  localparam int TO  = 50;
`ifdef RESPONSE_FRAMER_CHECKSUM_EN
  localparam int LAST = 2;
`else
  localparam int LAST = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       request_valid = 1'b0;
  logic       request_ready;
  logic [7:0] response_code = 8'h00;
  logic [7:0] response_value = 8'h00;
  logic       has_data;
  logic [7:0] data_to_send;
  logic       transmission_done = 1'b0;
  logic       frame_done;
  logic       timeout_error;
  logic [7:0] frame_count;

  int checks = 0;
  int failures = 0;
  int expCount = 0;
  logic [7:0] expBytes [3];

  always #5 clock = ~clock;

  response_framer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clock             (clock),
    .reset             (reset),
    .request_valid     (request_valid),
    .request_ready     (request_ready),
    .response_code     (response_code),
    .response_value    (response_value),
    .has_data          (has_data),
    .data_to_send      (data_to_send),
    .transmission_done (transmission_done),
    .frame_done        (frame_done),
    .timeout_error     (timeout_error),
    .frame_count       (frame_count)
  );

  // Advance to just after the next rising edge, where inputs are driven
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Stimulus only: from a SEND cycle, acknowledge nBytes bytes nDone clocks
  // after each strobe; returns in the cycle after the last acknowledge
  task automatic completeBytes(input int nBytes, input int nDone);
    for (int i = 0; i < nBytes; i++) begin
      repeat (nDone) step();
      transmission_done = 1'b1;
      step();
      transmission_done = 1'b0;
      if (i < nBytes - 1) repeat (GAP) step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    @(negedge clock);
    checks++; if (has_data !== 1'b0) begin failures++; $display("[TB] FAIL rst_has_data: got %b expected 0", has_data); end
    checks++; if (data_to_send !== 8'h00) begin failures++; $display("[TB] FAIL rst_data: got %h expected 00", data_to_send); end
    checks++; if (frame_count !== 8'h00) begin failures++; $display("[TB] FAIL rst_count: got %h expected 00", frame_count); end
    checks++; if ({frame_done, timeout_error} !== 2'b00) begin failures++; $display("[TB] FAIL rst_pulses: got %b expected 00", {frame_done, timeout_error}); end
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (request_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready: got %b expected 1", request_ready); end
    expCount = 0;
  endtask

  task automatic test_single_frame();
    expBytes[0] = 8'hA5; expBytes[1] = 8'h3C; expBytes[2] = 8'h99;
    response_code = 8'hA5; response_value = 8'h3C; request_valid = 1'b1;
    step();
    request_valid = 1'b0;
    for (int b = 0; b <= LAST; b++) begin
      @(negedge clock);
      checks++; if (has_data !== 1'b1) begin failures++; $display("[TB] FAIL sf_strobe%0d: got %b expected 1", b, has_data); end
      checks++; if (data_to_send !== expBytes[b]) begin failures++; $display("[TB] FAIL sf_byte%0d: got %h expected %h", b, data_to_send, expBytes[b]); end
      checks++; if (request_ready !== 1'b0) begin failures++; $display("[TB] FAIL sf_busy%0d: got %b expected 0", b, request_ready); end
      step();
      @(negedge clock);
      checks++; if (has_data !== 1'b0) begin failures++; $display("[TB] FAIL sf_strobe_len%0d: got %b expected 0", b, has_data); end
      repeat (9) step();
      transmission_done = 1'b1;
      step();
      transmission_done = 1'b0;
      if (b < LAST) begin
        @(negedge clock);
        checks++; if ({has_data, frame_done} !== 2'b00) begin failures++; $display("[TB] FAIL sf_gap%0d: got %b expected 00", b, {has_data, frame_done}); end
        step();
        @(negedge clock);
        checks++; if (has_data !== 1'b0) begin failures++; $display("[TB] FAIL sf_gap_end%0d: got %b expected 0", b, has_data); end
        step();
      end
    end
    expCount++;
    @(negedge clock);
    checks++; if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL sf_frame_done: got %b expected 1", frame_done); end
    checks++; if (frame_count !== 8'(expCount)) begin failures++; $display("[TB] FAIL sf_count: got %0d expected %0d", frame_count, expCount); end
    checks++; if (request_ready !== 1'b1) begin failures++; $display("[TB] FAIL sf_ready: got %b expected 1", request_ready); end
    step();
    @(negedge clock);
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL sf_done_pulse: got %b expected 0", frame_done); end
  endtask

  task automatic test_timeout();
    response_code = 8'h5A; response_value = 8'h01; request_valid = 1'b1;
    step();
    request_valid = 1'b0;
    repeat (TO - 1) step();
    @(negedge clock);
    checks++; if (timeout_error !== 1'b0) begin failures++; $display("[TB] FAIL to_early: got %b expected 0", timeout_error); end
    step();
    @(negedge clock);
    checks++; if (timeout_error !== 1'b1) begin failures++; $display("[TB] FAIL to_pulse: got %b expected 1", timeout_error); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL to_no_done: got %b expected 0", frame_done); end
    checks++; if (frame_count !== 8'(expCount)) begin failures++; $display("[TB] FAIL to_count: got %0d expected %0d", frame_count, expCount); end
    checks++; if (request_ready !== 1'b1) begin failures++; $display("[TB] FAIL to_ready: got %b expected 1", request_ready); end
    step();
    @(negedge clock);
    checks++; if ({timeout_error, has_data} !== 2'b00) begin failures++; $display("[TB] FAIL to_after: got %b expected 00", {timeout_error, has_data}); end
  endtask

  task automatic test_done_at_deadline();
    response_code = 8'h42; response_value = 8'h24; request_valid = 1'b1;
    step();
    request_valid = 1'b0;
    repeat (TO - 1) step();
    transmission_done = 1'b1;
    step();
    transmission_done = 1'b0;
    @(negedge clock);
    checks++; if (timeout_error !== 1'b0) begin failures++; $display("[TB] FAIL dl_no_timeout: got %b expected 0", timeout_error); end
    checks++; if (request_ready !== 1'b0) begin failures++; $display("[TB] FAIL dl_still_busy: got %b expected 0", request_ready); end
    repeat (GAP) step();
    @(negedge clock);
    checks++; if (data_to_send !== 8'h24) begin failures++; $display("[TB] FAIL dl_byte1: got %h expected 24", data_to_send); end
    completeBytes(LAST, 2);
    expCount++;
    @(negedge clock);
    checks++; if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL dl_frame_done: got %b expected 1", frame_done); end
  endtask

  task automatic test_busy_ignored();
    expBytes[0] = 8'hA5; expBytes[1] = 8'h3C; expBytes[2] = 8'h99;
    response_code = 8'hA5; response_value = 8'h3C; request_valid = 1'b1;
    step();
    response_code = 8'h11; response_value = 8'h22;
    for (int b = 0; b <= LAST; b++) begin
      @(negedge clock);
      checks++; if (data_to_send !== expBytes[b]) begin failures++; $display("[TB] FAIL bi_byte%0d: got %h expected %h", b, data_to_send, expBytes[b]); end
      repeat (4) step();
      transmission_done = 1'b1;
      step();
      transmission_done = 1'b0;
      if (b < LAST) repeat (GAP) step();
    end
    expCount++;
    @(negedge clock);
    checks++; if ({frame_done, request_ready} !== 2'b11) begin failures++; $display("[TB] FAIL bi_done_ready: got %b expected 11", {frame_done, request_ready}); end
    step();
    request_valid = 1'b0;
    @(negedge clock);
    checks++; if ({has_data, data_to_send} !== {1'b1, 8'h11}) begin failures++; $display("[TB] FAIL bi_next: got %b/%h expected 1/11", has_data, data_to_send); end
    completeBytes(LAST + 1, 3);
    expCount++;
    @(negedge clock);
    checks++; if (frame_count !== 8'(expCount)) begin failures++; $display("[TB] FAIL bi_count: got %0d expected %0d", frame_count, expCount); end
  endtask

  task automatic test_reset_midframe();
    logic seenStrobe;
    response_code = 8'h77; response_value = 8'h88; request_valid = 1'b1;
    step();
    request_valid = 1'b0;
    completeBytes(1, 3);
    repeat (GAP) step();
    step();
    reset = 1'b1;
    #2;
    checks++; if ({has_data, data_to_send} !== 9'h000) begin failures++; $display("[TB] FAIL rm_outputs: got %b/%h expected 0/00", has_data, data_to_send); end
    checks++; if (frame_count !== 8'h00) begin failures++; $display("[TB] FAIL rm_count_async: got %0d expected 0", frame_count); end
    step();
    reset = 1'b0;
    expCount = 0;
    seenStrobe = 1'b0;
    transmission_done = 1'b1;
    step();
    transmission_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      seenStrobe = seenStrobe | has_data | frame_done;
      step();
    end
    checks++; if (seenStrobe !== 1'b0) begin failures++; $display("[TB] FAIL rm_no_byte: got %b expected 0", seenStrobe); end
    @(negedge clock);
    checks++; if ({request_ready, frame_count} !== {1'b1, 8'h00}) begin failures++; $display("[TB] FAIL rm_idle: got %b/%0d expected 1/0", request_ready, frame_count); end
  endtask

  task automatic test_back_to_back();
    transmission_done = 1'b1;
    step();
    transmission_done = 1'b0;
    @(negedge clock);
    checks++; if ({has_data, request_ready} !== 2'b01) begin failures++; $display("[TB] FAIL bb_spurious: got %b expected 01", {has_data, request_ready}); end
    for (int i = 0; i < 256; i++) begin
      response_code = 8'(i); response_value = ~8'(i); request_valid = 1'b1;
      step();
      request_valid = 1'b0;
      completeBytes(LAST + 1, 1);
      expCount = (expCount + 1) % 256;
      @(negedge clock);
      checks++; if ({frame_done, timeout_error} !== 2'b10) begin failures++; $display("[TB] FAIL bb_done%0d: got %b expected 10", i, {frame_done, timeout_error}); end
      checks++; if (frame_count !== 8'(expCount)) begin failures++; $display("[TB] FAIL bb_count%0d: got %0d expected %0d", i, frame_count, expCount); end
    end
    checks++; if (frame_count !== 8'h00) begin failures++; $display("[TB] FAIL bb_wrap: got %0d expected 0", frame_count); end
  endtask

  // Absolute time limit so a stuck run still ends with a report
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_timeout();
    test_done_at_deadline();
    test_busy_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
